// File: rtl/alu_unit_sel.sv
// alu_unit_sel: decodes a function-select code into a registered one-hot
// unit enable that is held for HOLD cycles, with back-to-back reissue.
module alu_unit_sel #(
    parameter int unsigned         SEL_W     = 2,
    parameter int unsigned         HOLD      = 1,
    parameter logic [2**SEL_W-1:0] UNIT_MASK = '1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [SEL_W-1:0]      ALU_FUN,
    input  logic                  FUN_VLD,
    output logic                  FUN_RDY,
    output logic [2**SEL_W-1:0]   EN,
    output logic                  EN_VLD,
    output logic                  ERR,
    output logic                  BUSY
);

    localparam int unsigned N = 2**SEL_W;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_d;
    logic [N-1:0]     en_q;
    logic [N-1:0]     en_d;
    logic             err_q;
    logic             err_d;
    logic             cnt_zero;
    logic             accept;
    logic             hit;
    logic             miss;
    logic             hold;
    logic             drop;
    logic [SEL_W-1:0] idx;

    // Code k drives bit N-1-k, which is simply the bitwise complement.
    assign idx      = ~ALU_FUN;
    assign cnt_zero = (cnt_q == 4'd0);
    assign FUN_RDY  = RST && ((state_q == IDLE) || cnt_zero);
    assign accept   = FUN_VLD && FUN_RDY;

    assign hit  = accept && UNIT_MASK[idx];
    assign miss = accept && !UNIT_MASK[idx];
    assign hold = !accept && (state_q == ACTIVE) && !cnt_zero;
    assign drop = !accept && (state_q == ACTIVE) && cnt_zero;

    // Next-state decode: new command, error, hold countdown or release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        err_d   = 1'b0;
        unique case (1'b1)
            hit: begin
                en_d      = '0;
                en_d[idx] = 1'b1;
                cnt_d     = 4'(HOLD - 1);
                state_d   = ACTIVE;
            end
            miss: begin
                en_d    = '0;
                cnt_d   = 4'd0;
                err_d   = 1'b1;
                state_d = IDLE;
            end
            hold: begin
                cnt_d = cnt_q - 4'd1;
            end
            drop: begin
                en_d    = '0;
                state_d = IDLE;
            end
            default: begin
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            en_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            err_q   <= err_d;
        end
    end

    assign EN     = en_q;
    assign ERR    = err_q;
    assign EN_VLD = (state_q == ACTIVE);
    assign BUSY   = (state_q == ACTIVE);

endmodule

// File: tb/tb_alu_unit_sel.sv
// tb_alu_unit_sel: scoreboard bench over three configurations
// (HOLD=3 full mask, HOLD=3 mask 1011, HOLD=1 full mask).
module tb_alu_unit_sel;

    logic       clk;
    logic       rst;
    logic [1:0] fun_a, fun_b, fun_c;
    logic       vld_a, vld_b, vld_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [3:0] en_a, en_b, en_c;
    logic       env_a, env_b, env_c;
    logic       err_a, err_b, err_c;
    logic       bsy_a, bsy_b, bsy_c;

    int checks = 0;
    int passed = 0;

    // expected vector: {EN[3:0], EN_VLD, ERR, FUN_RDY, BUSY}
    logic [7:0] sb[$];

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic [1:0] fun;
        logic [7:0] exp;
    } stim_t;

    alu_unit_sel #(.SEL_W(2), .HOLD(3)) dut_a (
        .CLK(clk), .RST(rst), .ALU_FUN(fun_a), .FUN_VLD(vld_a),
        .FUN_RDY(rdy_a), .EN(en_a), .EN_VLD(env_a), .ERR(err_a),
        .BUSY(bsy_a)
    );

    alu_unit_sel #(.SEL_W(2), .HOLD(3), .UNIT_MASK(4'b1011)) dut_b (
        .CLK(clk), .RST(rst), .ALU_FUN(fun_b), .FUN_VLD(vld_b),
        .FUN_RDY(rdy_b), .EN(en_b), .EN_VLD(env_b), .ERR(err_b),
        .BUSY(bsy_b)
    );

    alu_unit_sel #(.SEL_W(2), .HOLD(1)) dut_c (
        .CLK(clk), .RST(rst), .ALU_FUN(fun_c), .FUN_VLD(vld_c),
        .FUN_RDY(rdy_c), .EN(en_c), .EN_VLD(env_c), .ERR(err_c),
        .BUSY(bsy_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input int sel, input logic r,
                         input logic v, input logic [1:0] f);
        rst   = r;
        vld_a = (sel == 0) && v;
        vld_b = (sel == 1) && v;
        vld_c = (sel == 2) && v;
        fun_a = f;
        fun_b = f;
        fun_c = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] obs(input int sel);
        case (sel)
            0:       return {en_a, env_a, err_a, rdy_a, bsy_a};
            1:       return {en_b, env_b, err_b, rdy_b, bsy_b};
            default: return {en_c, env_c, err_c, rdy_c, bsy_c};
        endcase
    endfunction

    task automatic test_reset();
        stim_t s[6];
        logic [7:0] got, want;
        s = '{
            '{1'b0, 1'b1, 2'b00, 8'b0000_0_0_0_0},
            '{1'b0, 1'b1, 2'b00, 8'b0000_0_0_0_0},
            '{1'b1, 1'b1, 2'b00, 8'b1000_1_0_0_1},
            '{1'b1, 1'b0, 2'b00, 8'b1000_1_0_0_1},
            '{1'b1, 1'b0, 2'b00, 8'b1000_1_0_1_1},
            '{1'b1, 1'b0, 2'b00, 8'b0000_0_0_1_0}
        };
        foreach (s[i]) begin
            drive(0, s[i].rst, s[i].vld, s[i].fun);
            sb.push_back(s[i].exp);
            tick();
            got  = obs(0);
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL reset[%0d]: got %b want %b", i, got, want);
            else
                passed++;
        end
    endtask

    task automatic test_hold();
        stim_t s[4];
        logic [7:0] got, want;
        s = '{
            '{1'b1, 1'b1, 2'b10, 8'b0010_1_0_0_1},
            '{1'b1, 1'b0, 2'b01, 8'b0010_1_0_0_1},
            '{1'b1, 1'b0, 2'b00, 8'b0010_1_0_1_1},
            '{1'b1, 1'b0, 2'b11, 8'b0000_0_0_1_0}
        };
        foreach (s[i]) begin
            drive(0, s[i].rst, s[i].vld, s[i].fun);
            sb.push_back(s[i].exp);
            tick();
            got  = obs(0);
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL hold[%0d]: got %b want %b", i, got, want);
            else
                passed++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[7];
        logic [7:0] got, want;
        s = '{
            '{1'b1, 1'b1, 2'b01, 8'b0100_1_0_0_1},
            '{1'b1, 1'b1, 2'b11, 8'b0100_1_0_0_1},
            '{1'b1, 1'b1, 2'b11, 8'b0100_1_0_1_1},
            '{1'b1, 1'b1, 2'b11, 8'b0001_1_0_0_1},
            '{1'b1, 1'b0, 2'b11, 8'b0001_1_0_0_1},
            '{1'b1, 1'b0, 2'b11, 8'b0001_1_0_1_1},
            '{1'b1, 1'b0, 2'b11, 8'b0000_0_0_1_0}
        };
        foreach (s[i]) begin
            drive(0, s[i].rst, s[i].vld, s[i].fun);
            sb.push_back(s[i].exp);
            tick();
            got  = obs(0);
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL b2b[%0d]: got %b want %b", i, got, want);
            else
                passed++;
        end
    endtask

    task automatic test_err();
        stim_t s[5];
        logic [7:0] got, want;
        s = '{
            '{1'b1, 1'b1, 2'b01, 8'b0000_0_1_1_0},
            '{1'b1, 1'b1, 2'b00, 8'b1000_1_0_0_1},
            '{1'b1, 1'b0, 2'b01, 8'b1000_1_0_0_1},
            '{1'b1, 1'b0, 2'b01, 8'b1000_1_0_1_1},
            '{1'b1, 1'b0, 2'b01, 8'b0000_0_0_1_0}
        };
        foreach (s[i]) begin
            drive(1, s[i].rst, s[i].vld, s[i].fun);
            sb.push_back(s[i].exp);
            tick();
            got  = obs(1);
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL err[%0d]: got %b want %b", i, got, want);
            else
                passed++;
        end
    endtask

    task automatic test_hold1();
        stim_t s[5];
        logic [7:0] got, want;
        s = '{
            '{1'b1, 1'b1, 2'b00, 8'b1000_1_0_1_1},
            '{1'b1, 1'b1, 2'b01, 8'b0100_1_0_1_1},
            '{1'b1, 1'b1, 2'b10, 8'b0010_1_0_1_1},
            '{1'b1, 1'b1, 2'b11, 8'b0001_1_0_1_1},
            '{1'b1, 1'b0, 2'b00, 8'b0000_0_0_1_0}
        };
        foreach (s[i]) begin
            drive(2, s[i].rst, s[i].vld, s[i].fun);
            sb.push_back(s[i].exp);
            tick();
            got  = obs(2);
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL hold1[%0d]: got %b want %b", i, got, want);
            else
                passed++;
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [1:0] f;
        logic [3:0] onehot;
        logic [7:0] got, want;
        for (int i = 0; i < 24; i++) begin
            v      = 1'($urandom_range(0, 1));
            f      = 2'($urandom_range(0, 3));
            onehot = v ? (4'b1000 >> f) : 4'b0000;
            drive(2, 1'b1, v, f);
            sb.push_back({onehot, v, 1'b0, 1'b1, v});
            tick();
            got  = obs(2);
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL rand[%0d]: got %b want %b", i, got, want);
            else
                passed++;
        end
    endtask

    task automatic test_reset_mid();
        stim_t s[7];
        logic [7:0] got, want;
        s = '{
            '{1'b1, 1'b1, 2'b11, 8'b0001_1_0_0_1},
            '{1'b1, 1'b0, 2'b11, 8'b0001_1_0_0_1},
            '{1'b0, 1'b0, 2'b11, 8'b0000_0_0_0_0},
            '{1'b1, 1'b1, 2'b10, 8'b0010_1_0_0_1},
            '{1'b1, 1'b0, 2'b10, 8'b0010_1_0_0_1},
            '{1'b1, 1'b0, 2'b10, 8'b0010_1_0_1_1},
            '{1'b1, 1'b0, 2'b10, 8'b0000_0_0_1_0}
        };
        foreach (s[i]) begin
            drive(0, s[i].rst, s[i].vld, s[i].fun);
            sb.push_back(s[i].exp);
            tick();
            got  = obs(0);
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL rstmid[%0d]: got %b want %b", i, got, want);
            else
                passed++;
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 2'b00);
        test_reset();
        test_hold();
        test_back_to_back();
        test_err();
        test_hold1();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
